// File: rtl/dmem_lsu.sv
// dmem_lsu: word-organised data memory behind a single-outstanding load/store
// front end. Each accepted request walks IDLE -> (WAIT) -> ACCESS -> RESP.
// Misaligned, illegal-size or out-of-range requests are flagged with err.
// Flagged requests never touch the RAM.
module dmem_lsu #(
  parameter int ADDR_W   = 14,
  parameter int DEPTH    = 3072,
  parameter int WAIT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [IDX_W:0] DEPTH_L = DEPTH[IDX_W:0];
  localparam logic [2:0]     WAIT_L  = WAIT_CYC[2:0];

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t           r_state;
  logic [2:0]       r_cnt;
  logic             r_we;
  logic [1:0]       r_size;
  logic             r_sext;
  logic [1:0]       r_lane;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_wdata;
  logic             r_bad;
  logic             r_ready;
  logic             r_done;
  logic             r_err;
  logic [31:0]      r_rdata;
  logic [31:0]      r_mem [DEPTH];

  logic             w_size_bad;
  logic             w_range_bad;
  logic             w_bad;
  logic [3:0]       w_be;
  logic [31:0]      w_wrep;

  // Select the byte/half field of a word and extend it to 32 bits.
  function automatic logic [31:0] load_ext(input logic [31:0] word,
                                           input logic [1:0]  sz,
                                           input logic [1:0]  lane,
                                           input logic        sx);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (sz)
      2'b00:   load_ext = {{24{sx & b[7]}}, b};
      2'b01:   load_ext = {{16{sx & h[15]}}, h};
      2'b10:   load_ext = word;
      default: load_ext = 32'h0000_0000;
    endcase
  endfunction

  assign w_range_bad = ({1'b0, addr[ADDR_W-1:2]} >= DEPTH_L);
  assign w_bad       = w_size_bad | w_range_bad;

  // Alignment / size legality of the request being offered right now.
  always_comb begin
    w_size_bad = 1'b0;
    case (size)
      2'b00:   w_size_bad = 1'b0;
      2'b01:   w_size_bad = addr[0];
      2'b10:   w_size_bad = (addr[1:0] != 2'b00);
      default: w_size_bad = 1'b1;
    endcase
  end

  // Byte enables and lane-replicated store data from the latched request.
  always_comb begin
    w_be   = 4'b0000;
    w_wrep = r_wdata;
    case (r_size)
      2'b00: begin
        w_be   = 4'b0001 << r_lane;
        w_wrep = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be   = r_lane[1] ? 4'b1100 : 4'b0011;
        w_wrep = {2{r_wdata[15:0]}};
      end
      2'b10: begin
        w_be   = 4'b1111;
        w_wrep = r_wdata;
      end
      default: begin
        w_be   = 4'b0000;
        w_wrep = r_wdata;
      end
    endcase
  end

  // Access sequencer: latch request, optional stall, single RAM edge, response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'h0000_0000;
      r_bad   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_rdata <= 32'h0000_0000;
          if (req && r_ready) begin
            r_we    <= we;
            r_size  <= size;
            r_sext  <= sign_ext;
            r_lane  <= addr[1:0];
            r_idx   <= addr[ADDR_W-1:2];
            r_wdata <= wdata;
            r_bad   <= w_bad;
            r_ready <= 1'b0;
            if (WAIT_CYC > 0) begin
              r_cnt   <= WAIT_L;
              r_state <= S_WAIT;
            end else begin
              r_state <= S_ACCESS;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt <= 3'd1) begin
            r_state <= S_ACCESS;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_ACCESS: begin
          r_state <= S_RESP;
          r_done  <= ~r_bad;
          r_err   <= r_bad;
          r_rdata <= (!r_bad && !r_we) ?
                     load_ext(r_mem[r_idx], r_size, r_lane, r_sext) : 32'h0000_0000;
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_rdata <= 32'h0000_0000;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // RAM write port: only in ACCESS, only for good stores, and never under reset.
  always_ff @(posedge clk) begin
    if (r_state == S_ACCESS && !rst && r_we && !r_bad) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[r_idx][8*i +: 8] <= w_wrep[8*i +: 8];
      end
    end
  end

  // Reset during RESP must hide the pulse that is already registered.
  assign ready = r_ready;
  assign done  = r_done & ~rst;
  assign err   = r_err & ~rst;
  assign rdata = rst ? 32'h0000_0000 : r_rdata;

endmodule

// File: tb/tb_dmem_lsu.sv
// Testbench for dmem_lsu: scoreboard-checked functional vectors on a zero-wait
// instance, plus cycle-accurate timing and reset cases on a WAIT_CYC=3 instance.
module tb_dmem_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, we, sext, ready, done, err;
  logic [1:0]  size;
  logic [13:0] addr;
  logic [31:0] wdata, rdata;

  logic        rst3, req3, we3, sext3, ready3, done3, err3;
  logic [1:0]  size3;
  logic [13:0] addr3;
  logic [31:0] wdata3, rdata3;

  dmem_lsu #(.ADDR_W(14), .DEPTH(3072), .WAIT_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign_ext(sext),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err), .rdata(rdata));

  dmem_lsu #(.ADDR_W(14), .DEPTH(3072), .WAIT_CYC(3)) dut3 (
    .clk(clk), .rst(rst3), .req(req3), .we(we3), .size(size3), .sign_ext(sext3),
    .addr(addr3), .wdata(wdata3), .ready(ready3), .done(done3), .err(err3), .rdata(rdata3));

  int tests = 0;
  int fails = 0;
  int n_issued = 0;
  int n_resp = 0;
  logic [32:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response of dut0 is matched against the oldest expectation.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst && (done || err)) begin
      n_resp++;
      if (exp_q.size() == 0) begin
        chk("resp_without_request", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("resp%0d_err", n_resp), {31'b0, err}, {31'b0, e[32]});
        chk($sformatf("resp%0d_done", n_resp), {31'b0, done}, {31'b0, ~e[32]});
        chk($sformatf("resp%0d_rdata", n_resp), rdata, e[31:0]);
      end
    end
  end

  // Offer one request to dut0 and record its expected response once accepted.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [13:0] a, input logic [31:0] wd,
                       input logic e_err, input logic [31:0] e_rd);
    int n = 0;
    we = w; size = sz; sext = sx; addr = a; wdata = wd; req = 1'b1;
    @(negedge clk);
    while (!ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!ready) begin
      chk("accept_timeout", 32'(n), 32'd0);
      req = 1'b0;
    end else begin
      exp_q.push_back({e_err, e_rd});
      n_issued++;
      @(posedge clk);
      #1 req = 1'b0;
    end
  endtask

  // Word access on dut3; rst3 is held during cycle T+rc (rc=0: no reset,
  // and the ready/done timeline is checked cycle by cycle).
  task automatic do3(input logic w, input logic [13:0] a, input logic [31:0] wd,
                     input int rc, output logic saw, output logic [31:0] rd);
    int n = 0;
    saw = 1'b0;
    rd  = 32'h0;
    we3 = w; size3 = 2'b10; sext3 = 1'b0; addr3 = a; wdata3 = wd; req3 = 1'b1;
    @(negedge clk);
    while (!ready3 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!ready3) begin
      chk("accept3_timeout", 32'(n), 32'd0);
      req3 = 1'b0;
    end else begin
      @(posedge clk);
      #1 req3 = 1'b0;
      for (int k = 1; k <= 7; k++) begin
        rst3 = (k == rc);
        @(negedge clk);
        if (done3) begin
          saw = 1'b1;
          rd  = rdata3;
        end
        if (rc == 0) begin
          chk($sformatf("w3_ready_T+%0d", k), {31'b0, ready3}, {31'b0, (k >= 6)});
          chk($sformatf("w3_done_T+%0d", k), {31'b0, done3}, {31'b0, (k == 5)});
        end
        @(posedge clk);
        #1;
      end
      rst3 = 1'b0;
    end
  endtask

  initial begin
    logic        s3;
    logic [31:0] r3;
    int          n;
    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sext = 1'b0; addr = 14'h0; wdata = 32'h0;
    rst3 = 1'b1; req3 = 1'b0; we3 = 1'b0; size3 = 2'b00; sext3 = 1'b0; addr3 = 14'h0; wdata3 = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ready3", {31'b0, ready3}, 32'd1);
    @(posedge clk);
    #1;

    // word store / load
    issue(1'b1, 2'b10, 1'b0, 14'h010, 32'hDEADBEEF, 1'b0, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 14'h010, 32'h0,        1'b0, 32'hDEADBEEF);
    // byte store into existing word, signed/unsigned byte loads
    issue(1'b1, 2'b10, 1'b0, 14'h010, 32'h11223344, 1'b0, 32'h0);
    issue(1'b1, 2'b00, 1'b0, 14'h011, 32'h000000AA, 1'b0, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 14'h010, 32'h0,        1'b0, 32'h1122AA44);
    issue(1'b0, 2'b00, 1'b1, 14'h011, 32'h0,        1'b0, 32'hFFFFFFAA);
    issue(1'b0, 2'b00, 1'b0, 14'h011, 32'h0,        1'b0, 32'h000000AA);
    // half stores and signed/unsigned half loads
    issue(1'b1, 2'b10, 1'b0, 14'h010, 32'h0,        1'b0, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 14'h012, 32'h00008001, 1'b0, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 14'h010, 32'h0,        1'b0, 32'h80010000);
    issue(1'b0, 2'b01, 1'b1, 14'h012, 32'h0,        1'b0, 32'hFFFF8001);
    issue(1'b0, 2'b01, 1'b0, 14'h012, 32'h0,        1'b0, 32'h00008001);
    issue(1'b1, 2'b01, 1'b0, 14'h010, 32'h12347FFF, 1'b0, 32'h0);
    issue(1'b0, 2'b01, 1'b1, 14'h010, 32'h0,        1'b0, 32'h00007FFF);
    issue(1'b0, 2'b10, 1'b0, 14'h010, 32'h0,        1'b0, 32'h80017FFF);
    // misalignment and illegal size: err, RAM untouched
    issue(1'b1, 2'b10, 1'b0, 14'h000, 32'hCAFEF00D, 1'b0, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 14'h013, 32'h0,        1'b1, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 14'h001, 32'h0000FFFF, 1'b1, 32'h0);
    issue(1'b1, 2'b11, 1'b0, 14'h010, 32'hFFFFFFFF, 1'b1, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 14'h000, 32'h0,        1'b0, 32'hCAFEF00D);
    issue(1'b0, 2'b10, 1'b0, 14'h010, 32'h0,        1'b0, 32'h80017FFF);
    // top byte lane; word load ignores sign_ext
    issue(1'b1, 2'b00, 1'b0, 14'h013, 32'h0000005A, 1'b0, 32'h0);
    issue(1'b0, 2'b00, 1'b1, 14'h013, 32'h0,        1'b0, 32'h0000005A);
    issue(1'b0, 2'b00, 1'b1, 14'h010, 32'h0,        1'b0, 32'hFFFFFFFF);
    issue(1'b0, 2'b10, 1'b1, 14'h010, 32'h0,        1'b0, 32'h5A017FFF);
    issue(1'b0, 2'b10, 1'b1, 14'h000, 32'h0,        1'b0, 32'hCAFEF00D);
    // range: index DEPTH rejected, index DEPTH-1 usable
    issue(1'b0, 2'b10, 1'b0, 14'h3000, 32'h0,        1'b1, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 14'h3000, 32'h00000001, 1'b1, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 14'h2FFC, 32'h0BADC0DE, 1'b0, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 14'h2FFC, 32'h0,        1'b0, 32'h0BADC0DE);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    chk("response_count", 32'(n_resp), 32'(n_issued));

    // WAIT_CYC=3 timing and reset behaviour
    do3(1'b1, 14'h040, 32'h12345678, 0, s3, r3);
    chk("w3_store_done", {31'b0, s3}, 32'd1);
    do3(1'b1, 14'h040, 32'h55555555, 2, s3, r3);
    chk("w3_rst_in_wait_no_done", {31'b0, s3}, 32'd0);
    do3(1'b1, 14'h040, 32'h66666666, 4, s3, r3);
    chk("w3_rst_at_access_no_done", {31'b0, s3}, 32'd0);
    do3(1'b0, 14'h040, 32'h0, 5, s3, r3);
    chk("w3_rst_in_resp_no_pulse", {31'b0, s3}, 32'd0);
    do3(1'b0, 14'h040, 32'h0, 0, s3, r3);
    chk("w3_load_done", {31'b0, s3}, 32'd1);
    chk("w3_word_unchanged", r3, 32'h12345678);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
